// File: rtl/memory_port_arbiter.sv
// Two-requester arbiter for the shared memory/stack address-value port: round-robin or
// fixed-priority grant (MEM_ARB_FIXED_PRIORITY_EN), bus locking, fixed-latency read return.

module memory_port_arbiter_resp #(
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              hit,
    input  logic [DATA_W-1:0] rd,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] held;

    always_ff @(posedge clock) begin
        if (reset)    held <= '0;
        else if (hit) held <= rd;
    end

    assign rvalid = hit;
    assign rdata  = hit ? rd : held;
endmodule

module memory_port_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int LOCK_MAX = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_lock,
    input  logic              r0_we,
    input  logic              r0_stack,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_lock,
    input  logic              r1_we,
    input  logic              r1_stack,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] value,
    output logic              memory_store_enable,
    output logic              stack_store_enable,
    input  logic [DATA_W-1:0] at_memory,
    input  logic [DATA_W-1:0] at_stack
);
    localparam int STAGES = 2;
    localparam logic [7:0] LOCK_LAST = 8'(LOCK_MAX - 1);

    typedef enum logic [1:0] {FREE, OWN0, OWN1} state_t;
    typedef struct packed {
        logic id;
        logic we;
        logic stack;
    } tag_t;

    logic [1:0]             req, lock, we, stk, gnt, hit, rvalid;
    logic [1:0][ADDR_W-1:0] addr;
    logic [1:0][DATA_W-1:0] wdata, rdata;

    assign req   = {r1_req, r0_req};
    assign lock  = {r1_lock, r0_lock};
    assign we    = {r1_we, r0_we};
    assign stk   = {r1_stack, r0_stack};
    assign addr  = {r1_addr, r0_addr};
    assign wdata = {r1_wdata, r0_wdata};

    state_t     state, state_nxt;
    logic [7:0] lock_cnt, lock_cnt_nxt;
    logic       acc, sel, own;
    tag_t       tag0;
    logic [STAGES:1] vld_pipe;
    tag_t            tag_pipe [STAGES:1];

`ifndef MEM_ARB_FIXED_PRIORITY_EN
    logic rr_ptr, rr_nxt;
`endif

    assign own = (state == OWN1);

    always_comb begin
        gnt = '0;
        if (!reset) begin
            case (state)
                FREE: begin
                    if (&req) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
                        gnt[0] = 1'b1;
`else
                        gnt[rr_ptr] = 1'b1;
`endif
                    end else begin
                        gnt = req;
                    end
                end
                OWN0:    gnt[0] = req[0];
                OWN1:    gnt[1] = req[1];
                default: gnt = '0;
            endcase
        end
    end

    assign acc  = |gnt;
    assign sel  = gnt[1];
    assign tag0 = '{id: sel, we: we[sel], stack: stk[sel]};

    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
        rr_nxt = rr_ptr;
        if (acc) rr_nxt = ~sel;
`endif
        case (state)
            FREE: begin
                // With LOCK_MAX=1 the first locked grant already exhausts the budget.
                if (acc && lock[sel] && LOCK_LAST != 8'd0) begin
                    state_nxt    = sel ? OWN1 : OWN0;
                    lock_cnt_nxt = 8'd1;
                end
            end
            OWN0, OWN1: begin
                if (gnt[own]) begin
                    if (!lock[own] || lock_cnt >= LOCK_LAST) begin
                        state_nxt    = FREE;
                        lock_cnt_nxt = 8'd0;
                    end else begin
                        lock_cnt_nxt = lock_cnt + 8'd1;
                    end
                end else if (!req[own] && !lock[own]) begin
                    state_nxt    = FREE;
                    lock_cnt_nxt = 8'd0;
                end
            end
            default: begin
                state_nxt    = FREE;
                lock_cnt_nxt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state               <= FREE;
            lock_cnt            <= 8'd0;
            vld_pipe            <= '0;
            address             <= '0;
            value               <= '0;
            memory_store_enable <= 1'b0;
            stack_store_enable  <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
            rr_ptr              <= 1'b0;
`endif
        end else begin
            state               <= state_nxt;
            lock_cnt            <= lock_cnt_nxt;
            vld_pipe            <= {vld_pipe[STAGES-1:1], acc};
            memory_store_enable <= acc & tag0.we & ~tag0.stack;
            stack_store_enable  <= acc & tag0.we & tag0.stack;
            if (acc) begin
                address <= addr[sel];
                value   <= wdata[sel];
            end
`ifndef MEM_ARB_FIXED_PRIORITY_EN
            rr_ptr <= rr_nxt;
`endif
        end
    end

    // Tags travel alongside vld_pipe so each response returns to its own issuer.
    always_ff @(posedge clock) begin
        tag_pipe[1] <= tag0;
        for (int s = 2; s <= STAGES; s++) tag_pipe[s] <= tag_pipe[s-1];
    end

    logic [DATA_W-1:0] rd_mux;
    assign rd_mux = tag_pipe[STAGES].stack ? at_stack : at_memory;

    for (genvar n = 0; n < 2; n++) begin : g_hit
        assign hit[n] = vld_pipe[STAGES] & ~tag_pipe[STAGES].we & (tag_pipe[STAGES].id == 1'(n));
    end

    memory_port_arbiter_resp #(.DATA_W(DATA_W)) u_resp [1:0] (
        .clock  (clock),
        .reset  (reset),
        .hit    (hit),
        .rd     (rd_mux),
        .rvalid (rvalid),
        .rdata  (rdata)
    );

    assign r0_gnt    = gnt[0];
    assign r1_gnt    = gnt[1];
    assign r0_rvalid = rvalid[0];
    assign r1_rvalid = rvalid[1];
    assign r0_rdata  = rdata[0];
    assign r1_rdata  = rdata[1];
endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: behavioural memory, reference contents and a response
// scoreboard checked every cycle; scenario tasks check grants and the issue stage.
module tb_memory_port_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int LM = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic r0_req = 0, r0_lock = 0, r0_we = 0, r0_stack = 0;
    logic r1_req = 0, r1_lock = 0, r1_we = 0, r1_stack = 0;
    logic [AW-1:0] r0_addr = '0, r1_addr = '0;
    logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
    logic r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic [AW-1:0] address;
    logic [DW-1:0] value;
    logic memory_store_enable, stack_store_enable;
    logic [DW-1:0] at_memory, at_stack;

    memory_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
        .clock(clock), .reset(reset),
        .r0_req(r0_req), .r0_lock(r0_lock), .r0_we(r0_we), .r0_stack(r0_stack),
        .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_gnt(r0_gnt),
        .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_lock(r1_lock), .r1_we(r1_we), .r1_stack(r1_stack),
        .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_gnt(r1_gnt),
        .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .address(address), .value(value),
        .memory_store_enable(memory_store_enable), .stack_store_enable(stack_store_enable),
        .at_memory(at_memory), .at_stack(at_stack)
    );

    always #5 clock = ~clock;

    // Memory: samples address/enables at the end of the issue cycle.
    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] stk [0:255];
    always @(posedge clock) begin
        if (memory_store_enable) mem[address[7:0]] <= value;
        if (stack_store_enable)  stk[address[7:0]] <= value;
        at_memory <= mem[address[7:0]];
        at_stack  <= stk[address[7:0]];
    end

    typedef struct {
        int          id;
        logic [DW-1:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];
    logic [DW-1:0] ref_mem [0:255];
    logic [DW-1:0] ref_stk [0:255];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic g0, g1;

    task automatic accept(input int id, input logic we, input logic st,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        if (we) begin
            if (st) ref_stk[a[7:0]] = d;
            else    ref_mem[a[7:0]] = d;
        end else begin
            e.id = id;
            e.data = st ? ref_stk[a[7:0]] : ref_mem[a[7:0]];
            e.due = cyc + 2;
            sb.push_back(e);
        end
    endtask

    // One clock: sample at negedge, check responses and grant sanity, log accepts.
    task automatic tick();
        exp_t e;
        @(negedge clock);
        cyc++;
        g0 = r0_gnt;
        g1 = r1_gnt;
        total++;
        if ((g0 && g1) || (g0 && !r0_req) || (g1 && !r1_req)) begin
            bad++;
            $display("FAIL gnt_sanity cyc=%0d gnt=%b%b req=%b%b", cyc, g1, g0, r1_req, r0_req);
        end
        total++;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            if (e.id == 0) begin
                if (r0_rvalid !== 1'b1 || r1_rvalid !== 1'b0 || r0_rdata !== e.data) begin
                    bad++;
                    $display("FAIL resp_r0 cyc=%0d rvalid=%b%b rdata=%h want r0 rdata=%h",
                             cyc, r1_rvalid, r0_rvalid, r0_rdata, e.data);
                end
            end else begin
                if (r1_rvalid !== 1'b1 || r0_rvalid !== 1'b0 || r1_rdata !== e.data) begin
                    bad++;
                    $display("FAIL resp_r1 cyc=%0d rvalid=%b%b rdata=%h want r1 rdata=%h",
                             cyc, r1_rvalid, r0_rvalid, r1_rdata, e.data);
                end
            end
        end else if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL stray_rvalid cyc=%0d rvalid=%b%b want 00", cyc, r1_rvalid, r0_rvalid);
        end
        if (reset) sb.delete();
        else begin
            if (g0) accept(0, r0_we, r0_stack, r0_addr, r0_wdata);
            if (g1) accept(1, r1_we, r1_stack, r1_addr, r1_wdata);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int id, input logic rq, input logic we, input logic st,
                           input logic [AW-1:0] a, input logic [DW-1:0] d, input logic lk);
        if (id == 0) begin
            r0_req = rq; r0_we = we; r0_stack = st; r0_addr = a; r0_wdata = d; r0_lock = lk;
        end else begin
            r1_req = rq; r1_we = we; r1_stack = st; r1_addr = a; r1_wdata = d; r1_lock = lk;
        end
    endtask

    task automatic issue1(input int id, input logic we, input logic st, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic lk, output int waited);
        logic got;
        got = 1'b0;
        waited = 0;
        set_req(id, 1'b1, we, st, a, d, lk);
        while (!got && waited < 20) begin
            tick();
            waited++;
            got = (id == 0) ? g0 : g1;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL issue_timeout r%0d waited=%0d want grant", id, waited);
        end
        if (id == 0) r0_req = 1'b0;
        else         r1_req = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0, 1'b0);
        set_req(1, 1'b1, 1'b0, 1'b1, 16'h0003, 16'h0, 1'b0);
        tick();
        tick();
        total++;
        if (g0 !== 1'b0 || g1 !== 1'b0) begin
            bad++; $display("FAIL reset_gnt gnt=%b%b want 00", g1, g0);
        end
        set_req(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        set_req(1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        reset = 1'b0;
        total++;
        if (address !== '0 || value !== '0 || memory_store_enable !== 1'b0 ||
            stack_store_enable !== 1'b0 || r0_rdata !== '0 || r1_rdata !== '0) begin
            bad++;
            $display("FAIL reset_outputs addr=%h val=%h en=%b%b rdata=%h/%h want all 0",
                     address, value, memory_store_enable, stack_store_enable, r0_rdata, r1_rdata);
        end
    endtask

    task automatic test_write();
        int w;
        issue1(0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 1'b0, w);
        total++;
        if (w !== 1) begin bad++; $display("FAIL write_gnt_latency waited=%0d want 1", w); end
        total++;
        if (address !== 16'h0010 || value !== 16'hBEEF || memory_store_enable !== 1'b1 ||
            stack_store_enable !== 1'b0) begin
            bad++;
            $display("FAIL write_issue addr=%h val=%h mse=%b sse=%b want 0010 BEEF 1 0",
                     address, value, memory_store_enable, stack_store_enable);
        end
        tick();
        total++;
        if (memory_store_enable !== 1'b0 || address !== 16'h0010) begin
            bad++;
            $display("FAIL write_idle mse=%b addr=%h want 0 0010", memory_store_enable, address);
        end
        drain(2);
    endtask

    task automatic test_read();
        int w;
        issue1(0, 1'b0, 1'b0, 16'h0010, 16'h0, 1'b0, w);
        total++;
        if (memory_store_enable !== 1'b0 || stack_store_enable !== 1'b0) begin
            bad++;
            $display("FAIL read_issue_en en=%b%b want 00", memory_store_enable, stack_store_enable);
        end
        drain(3);
        total++;
        if (r0_rvalid !== 1'b0 || r0_rdata !== 16'hBEEF) begin
            bad++;
            $display("FAIL rdata_hold rvalid=%b rdata=%h want 0 BEEF", r0_rvalid, r0_rdata);
        end
    endtask

    task automatic test_lock();
        set_req(0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0, 1'b0);
        for (int t = 0; t <= LM; t++) begin
            set_req(1, 1'b1, 1'b1, 1'b1, 16'(t), 16'h5A00 + 16'(t), 1'b1);
            if (t >= 1) r0_req = 1'b1;
            tick();
            total++;
            if (g1 !== (t < LM) || g0 !== (t == LM)) begin
                bad++;
                $display("FAIL lock_seq t=%0d gnt=%b%b want %b%b", t, g1, g0, t < LM, t == LM);
            end
        end
        set_req(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        set_req(1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        drain(3);
    endtask

    task automatic test_round_robin();
        int w;
        logic e0;
        issue1(1, 1'b0, 1'b1, 16'h0003, 16'h0, 1'b0, w);
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0, 1'b0);
        set_req(1, 1'b1, 1'b0, 1'b1, 16'h0003, 16'h0, 1'b0);
        for (int t = 0; t < 8; t++) begin
            tick();
`ifdef MEM_ARB_FIXED_PRIORITY_EN
            e0 = 1'b1;
`else
            e0 = (t % 2 == 0);
`endif
            total++;
            if (g0 !== e0 || g1 !== ~e0) begin
                bad++;
                $display("FAIL rr_seq t=%0d gnt=%b%b want %b%b", t, g1, g0, ~e0, e0);
            end
        end
        r0_req = 1'b0;
        r1_req = 1'b0;
        drain(3);
    endtask

    task automatic test_back_to_back();
        int w;
        issue1(0, 1'b1, 1'b0, 16'h0001, 16'h1111, 1'b0, w);
        issue1(1, 1'b1, 1'b1, 16'h0001, 16'h2222, 1'b0, w);
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0001, 16'h0, 1'b0);
        tick();
        total++;
        if (g0 !== 1'b1) begin bad++; $display("FAIL b2b_gnt0 gnt0=%b want 1", g0); end
        r0_req = 1'b0;
        set_req(1, 1'b1, 1'b0, 1'b1, 16'h0001, 16'h0, 1'b0);
        tick();
        total++;
        if (g1 !== 1'b1) begin bad++; $display("FAIL b2b_gnt1 gnt1=%b want 1", g1); end
        r1_req = 1'b0;
        // Read-after-write on consecutive accepts.
        set_req(0, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h1234, 1'b0);
        tick();
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0, 1'b0);
        tick();
        r0_req = 1'b0;
        drain(3);
    endtask

    task automatic test_reset_mid();
        int w;
        issue1(0, 1'b0, 1'b0, 16'h0010, 16'h0, 1'b1, w);
        set_req(0, 1'b1, 1'b1, 1'b0, 16'h0030, 16'hDEAD, 1'b1);
        reset = 1'b1;
        tick();
        total++;
        if (g0 !== 1'b0 || memory_store_enable !== 1'b0 || stack_store_enable !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid gnt0=%b en=%b%b want 0 00",
                     g0, memory_store_enable, stack_store_enable);
        end
        reset = 1'b0;
        r0_req = 1'b0;
        issue1(1, 1'b0, 1'b1, 16'h0003, 16'h0, 1'b0, w);
        total++;
        if (w !== 1) begin bad++; $display("FAIL reset_free waited=%0d want 1", w); end
        r0_lock = 1'b0;
        drain(3);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_lock();
        test_round_robin();
        test_back_to_back();
        test_reset_mid();
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL sb_leftover size=%0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
